lru_age_tracker: RTL and testbench
==================================

Name: lru_age_tracker

Overview:
- Parametrised N-way LRU replacement-state block for the set-associative cache.
- Holds one age counter per way per set and applies the LRU update on each access; it no longer relies on the cache controller to compute new ages.
- Returns the victim way on a miss and provides a multi-cycle flush sweep that restores every set to its reset ordering.
- Sits beside the tag/data arrays and is driven by the cache controller FSM.

Parameters:
- NUM_WAYS, 4, associativity; power of two, >= 2.
- NUM_SETS, 64, number of sets; >= 2.
- INDEX_W, $clog2(NUM_SETS), set index width.
- AGE_W (localparam), $clog2(NUM_WAYS), width of each age counter and of a way number.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  access request.
- req_ready  output  1  request accepted when req_valid && req_ready.
- req_index  input  INDEX_W  set being accessed.
- req_hit  input  1  1 = hit in req_way; 0 = miss, block must pick a victim.
- req_way  input  AGE_W  hit way; ignored when req_hit=0.
- resp_valid  output  1  one-cycle pulse, the cycle after acceptance.
- resp_way  output  AGE_W  way touched: req_way on a hit, victim on a miss.
- resp_hit  output  1  registered echo of req_hit.
- resp_index  output  INDEX_W  registered echo of req_index.
- flush_start  input  1  start a flush sweep; honoured only in IDLE.
- busy  output  1  high while a flush is in progress.

Behaviour:
- Storage: age[set][way], AGE_W bits each. Invariant: within every set the ages form a permutation of 0..NUM_WAYS-1. Age 0 = MRU, age NUM_WAYS-1 = LRU.
- Reset (reset=0, async): age[s][w]=w for all s and w; state=IDLE; flush counter=0; resp_valid=0, resp_way=0, resp_hit=0, resp_index=0.
- States: IDLE, FLUSH.
- req_ready = (state==IDLE) && !flush_start. This is combinational; flush has priority over a request in the same cycle.
- Access lookup: a read of age[req_index] in the acceptance cycle (combinational).
- Victim: the way whose age == NUM_WAYS-1. Touched way T = req_way on a hit, else the victim.
- Access update, at the acceptance edge:
  - age[T] <= 0.
  - Every way w with age[w] < old age[T] is incremented.
  - Ways with larger age are unchanged.
  - A hit on a way already at age 0 leaves the set unchanged.
- Latency: 1 cycle.
  - Storage is updated at the acceptance edge.
  - resp_* are registered at the same edge and resp_valid is high for exactly one cycle.
  - Back-to-back requests to the same index are legal every cycle and always see the updated ages; no hazard logic is needed.
- Flush, IDLE -> FLUSH:
  - Entered when flush_start=1 in IDLE, at the next edge; counter=0.
  - In FLUSH, each cycle writes age[counter][w]=w and increments the counter.
  - After writing set NUM_SETS-1, returns to IDLE; a flush takes exactly NUM_SETS cycles.
  - busy=1 for the whole of FLUSH.
  - flush_start in FLUSH is ignored; req_ready=0 in FLUSH.
- resp_valid is 0 in every cycle not directly following an accepted request.
- Reset mid-flush: all sets are reinitialised at once, state returns to IDLE, busy drops asynchronously.
- Widths: age arithmetic uses AGE_W bits. Increments cannot overflow because the permutation invariant holds.

Decomposition:
- Package lru_pkg: the state enum (IDLE, FLUSH) and a function oldest_way(ages) returning the way at age NUM_WAYS-1.
- Sub-module lru_age_update: purely combinational. Inputs are the current ages of one set and T; outputs are the next ages. It is instantiated once and is reusable by the future pseudo-LRU variant.

Test Plan:
- NUM_WAYS=4, NUM_SETS=8. Release reset; miss on set 3 -> resp_valid next cycle, resp_way=3; set 3 ages become {1,2,3,0}.
- Second miss on set 3 -> resp_way=2; ages {2,3,0,1}. Four consecutive misses to set 6 on back-to-back cycles -> resp_way 3,2,1,0.
- Hit way 0 on fresh set 5 -> ages unchanged {0,1,2,3}. Then hit way 2 -> ages {1,2,0,3}. Then miss -> resp_way=3.
- Dirty sets 1 and 7, then pulse flush_start -> busy high for exactly 8 cycles and req_ready=0 throughout. Afterwards a miss on set 7 -> resp_way=3.
- Assert req_valid and flush_start in the same IDLE cycle -> request not accepted, no resp_valid, flush starts. The request is accepted in the first IDLE cycle after the flush.
- Assert reset low during cycle 4 of a flush -> busy=0 immediately, all resp_* = 0. After release, a miss on any set returns way 3.
- Continuous assertion: every set's ages remain a permutation after every edge.

Source files
------------

// File: rtl/lru_pkg.sv
// Shared types and helpers for the LRU age tracker family.
// Ages are passed to helpers in a max-sized vector so one function serves every NUM_WAYS.
package lru_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam int MAX_WAYS  = 64;
  localparam int MAX_AGE_W = 6;

  typedef logic [MAX_WAYS-1:0][MAX_AGE_W-1:0] age_vec_t;

  // Way currently holding the LRU age (num_ways-1); lanes at or above num_ways are ignored.
  function automatic logic [MAX_AGE_W-1:0] oldest_way(input age_vec_t ages, input int num_ways);
    logic [MAX_AGE_W-1:0] res;
    res = '0;
    for (int w = 0; w < MAX_WAYS; w++) begin
      if (w < num_ways && ages[w] == MAX_AGE_W'(num_ways - 1)) begin
        res = MAX_AGE_W'(w);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/lru_age_update.sv
// Combinational next-age calculation for one set: touched way becomes MRU (age 0).
// Zero latency, no flow control; ways younger than the touched way age by one.
module lru_age_update #(
  parameter int NUM_WAYS = 4,
  localparam int AGE_W = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0][AGE_W-1:0] i_ages,
  input  logic [AGE_W-1:0]               i_touch,
  output logic [NUM_WAYS-1:0][AGE_W-1:0] o_ages
);

  logic [AGE_W-1:0] w_old;

  assign w_old = i_ages[i_touch];

  always_comb begin
    o_ages = i_ages;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (AGE_W'(w) == i_touch) begin
        o_ages[w] = '0;
      end else if (i_ages[w] < w_old) begin
        o_ages[w] = i_ages[w] + AGE_W'(1);
      end
    end
  end

endmodule

// File: rtl/lru_age_tracker.sv
// N-way true-LRU age store per set: updates on each access, reports victim, flush sweep.
// Response 1 cycle after acceptance; req_ready low during flush or when flush_start is asserted.
module lru_age_tracker
  import lru_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 64,
  parameter int INDEX_W  = $clog2(NUM_SETS),
  localparam int AGE_W   = $clog2(NUM_WAYS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [INDEX_W-1:0] req_index,
  input  logic               req_hit,
  input  logic [AGE_W-1:0]   req_way,
  output logic               resp_valid,
  output logic [AGE_W-1:0]   resp_way,
  output logic               resp_hit,
  output logic [INDEX_W-1:0] resp_index,
  input  logic               flush_start,
  output logic               busy
);

  typedef logic [NUM_WAYS-1:0][AGE_W-1:0] set_ages_t;

  set_ages_t        r_age [NUM_SETS];
  state_t           r_state;
  logic [INDEX_W-1:0] r_cnt;

  set_ages_t        w_cur;
  set_ages_t        w_next;
  age_vec_t         w_pack;
  logic [AGE_W-1:0] w_victim;
  logic [AGE_W-1:0] w_touch;
  logic             w_accept;

  assign req_ready = (r_state == IDLE) && !flush_start;
  assign w_accept  = req_valid && req_ready;
  assign busy      = (r_state == FLUSH);
  assign w_cur     = r_age[req_index];

  always_comb begin
    w_pack = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      w_pack[w] = MAX_AGE_W'(w_cur[w]);
    end
  end

  assign w_victim = AGE_W'(oldest_way(w_pack, NUM_WAYS));
  assign w_touch  = req_hit ? req_way : w_victim;

  lru_age_update #(
    .NUM_WAYS(NUM_WAYS)
  ) u_age_update (
    .i_ages  (w_cur),
    .i_touch (w_touch),
    .o_ages  (w_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          r_age[s][w] <= AGE_W'(w);
        end
      end
      r_state    <= IDLE;
      r_cnt      <= '0;
      resp_valid <= 1'b0;
      resp_way   <= '0;
      resp_hit   <= 1'b0;
      resp_index <= '0;
    end else begin
      resp_valid <= w_accept;
      if (w_accept) begin
        r_age[req_index] <= w_next;
        resp_way         <= w_touch;
        resp_hit         <= req_hit;
        resp_index       <= req_index;
      end
      // Accepts only happen in IDLE, so the sweep below never collides with an access write.
      case (r_state)
        IDLE: begin
          if (flush_start) begin
            r_state <= FLUSH;
            r_cnt   <= '0;
          end
        end
        FLUSH: begin
          for (int w = 0; w < NUM_WAYS; w++) begin
            r_age[r_cnt][w] <= AGE_W'(w);
          end
          r_cnt <= r_cnt + INDEX_W'(1);
          if (r_cnt == INDEX_W'(NUM_SETS - 1)) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lru_age_tracker.sv
// Randomised bench for lru_age_tracker against a recency-list model (front = MRU).
// Age of a way is its position in the list; the victim is the list tail.
module tb_lru_age_tracker;

  localparam int NW = 4;
  localparam int NS = 8;
  localparam int IW = 3;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [IW-1:0] req_index = '0;
  logic          req_hit = 1'b0;
  logic [AW-1:0] req_way = '0;
  logic          resp_valid;
  logic [AW-1:0] resp_way;
  logic          resp_hit;
  logic [IW-1:0] resp_index;
  logic          flush_start = 1'b0;
  logic          busy;

  int n_chk = 0;
  int n_bad = 0;
  int order [NS][NW];

  lru_age_tracker #(
    .NUM_WAYS(NW),
    .NUM_SETS(NS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_index   (req_index),
    .req_hit     (req_hit),
    .req_way     (req_way),
    .resp_valid  (resp_valid),
    .resp_way    (resp_way),
    .resp_hit    (resp_hit),
    .resp_index  (resp_index),
    .flush_start (flush_start),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    for (int s = 0; s < NS; s++)
      for (int p = 0; p < NW; p++)
        order[s][p] = p;
  endtask

  function automatic int mdl_age(input int s, input int w);
    int a;
    a = -1;
    for (int p = 0; p < NW; p++)
      if (order[s][p] == w) a = p;
    return a;
  endfunction

  task automatic mdl_touch(input int s, input int t);
    int p;
    p = mdl_age(s, t);
    for (int i = p; i > 0; i--) order[s][i] = order[s][i-1];
    order[s][0] = t;
  endtask

  task automatic chk_ages();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++)
        chk($sformatf("age_s%0d_w%0d", s, w), int'(dut.r_age[s][w]), mdl_age(s, w));
  endtask

  always @(negedge clk) begin
    logic [NW-1:0] mask;
    if (reset) begin
      for (int s = 0; s < NS; s++) begin
        mask = '0;
        for (int w = 0; w < NW; w++) mask = mask | (NW'(1) << dut.r_age[s][w]);
        chk($sformatf("perm_s%0d", s), int'(mask), (1 << NW) - 1);
      end
    end
  end

  // Called at posedge+1; leaves req_valid low so a following call makes it back-to-back.
  task automatic acc(input int idx, input bit hit, input int way);
    int t;
    req_valid = 1'b1;
    req_index = IW'(idx);
    req_hit   = hit;
    req_way   = AW'(way);
    @(negedge clk);
    chk("req_ready", int'(req_ready), 1);
    t = hit ? way : order[idx][NW-1];
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("resp_valid", int'(resp_valid), 1);
    chk("resp_way", int'(resp_way), t);
    chk("resp_hit", int'(resp_hit), int'(hit));
    chk("resp_index", int'(resp_index), idx);
    mdl_touch(idx, t);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("resp_pulse_end", int'(resp_valid), 0);
    end
  endtask

  task automatic flush_run(input bit with_req, input int idx);
    int cnt;
    int guard;
    int t;
    flush_start = 1'b1;
    if (with_req) begin
      req_valid = 1'b1;
      req_index = IW'(idx);
      req_hit   = 1'b0;
    end
    @(negedge clk);
    chk("ready_vs_flush", int'(req_ready), 0);
    @(posedge clk);
    #1;
    flush_start = 1'b0;
    chk("flush_entered", int'(busy), 1);
    cnt = 0;
    guard = 0;
    while (busy && guard < 100) begin
      chk("ready_in_flush", int'(req_ready), 0);
      chk("no_resp_in_flush", int'(resp_valid), 0);
      cnt++;
      guard++;
      @(posedge clk);
      #1;
    end
    chk("flush_len", cnt, NS);
    mdl_reset();
    if (with_req) begin
      @(negedge clk);
      chk("ready_after_flush", int'(req_ready), 1);
      t = order[idx][NW-1];
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("held_req_valid", int'(resp_valid), 1);
      chk("held_req_way", int'(resp_way), t);
      mdl_touch(idx, t);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int way;
    bit hit;

    mdl_reset();
    #12;
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_resp_way", int'(resp_way), 0);
    chk("rst_resp_hit", int'(resp_hit), 0);
    chk("rst_resp_index", int'(resp_index), 0);
    chk("rst_busy", int'(busy), 0);
    chk_ages();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    acc(3, 1'b0, 0);
    chk("set3_packed", int'(dut.r_age[3]), 8'h39);
    acc(3, 1'b0, 1);
    idle(1);
    repeat (4) acc(6, 1'b0, 2);
    idle(1);
    acc(5, 1'b1, 0);
    acc(5, 1'b1, 2);
    acc(5, 1'b0, 1);
    chk_ages();

    acc(1, 1'b0, 0);
    acc(7, 1'b1, 3);
    acc(7, 1'b0, 0);
    flush_run(1'b0, 0);
    chk_ages();
    acc(7, 1'b0, 1);

    flush_run(1'b1, 2);
    chk_ages();

    repeat (300) begin
      idx = int'($urandom_range(NS - 1, 0));
      way = int'($urandom_range(NW - 1, 0));
      hit = 1'($urandom_range(1, 0));
      acc(idx, hit, way);
      if ($urandom_range(3, 0) == 0) idle(1);
    end
    chk_ages();

    acc(5, 1'b1, 2);
    flush_start = 1'b1;
    @(posedge clk);
    #1;
    flush_start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("midflush_busy", int'(busy), 0);
    chk("midflush_resp_valid", int'(resp_valid), 0);
    chk("midflush_resp_way", int'(resp_way), 0);
    chk("midflush_resp_hit", int'(resp_hit), 0);
    chk("midflush_resp_index", int'(resp_index), 0);
    mdl_reset();
    chk_ages();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    acc(int'($urandom_range(NS - 1, 0)), 1'b0, 0);
    chk("post_reset_way", int'(resp_way), NW - 1);
    idle(2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
